bru_pipe: RTL

Parametrised, pipelined branch resolution unit for the execute stage. Compares two XLEN-bit operands, evaluates the RISC-V branch condition, and computes the jump/branch target and link address. Checks the result against the fetch-stage prediction and reports a redirect on mispredict. Two registered stages with valid/ready handshake, flush support and optional performance counters.

---
 rtl/bru_pkg.sv | 31 +++
 rtl/bru_pipe_if.sv | 25 ++
 rtl/bru_cmp.sv | 13 +
 rtl/bru_pipe.sv | 121 ++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// bru_pkg: shared types, constants and branch-condition helpers for bru_pipe
package bru_pkg;
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_BR   = 2'b01,
    OP_JAL  = 2'b10,
    OP_JALR = 2'b11
  } bru_op_e;
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;
  typedef struct packed {
    bru_op_e    op;
    logic [2:0] funct3;
    logic       less;
    logic       equal;
    logic       pred_taken;
  } bru_s1_t;
  localparam int unsigned LINK_OFFSET = 4;
  function automatic logic br_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction
  function automatic logic br_cond(input logic [2:0] f3, input logic less, input logic equal);
    return (f3[2] ? less : equal) ^ f3[0];
  endfunction
endpackage

// File: rtl/bru_pipe_if.sv
// bru_pipe_if: handshake, operand and result bundle of the branch resolution unit
interface bru_pipe_if #(parameter int XLEN = 32, parameter int CNT_W = 32);
  logic             i_flush, i_valid, o_ready;
  logic [1:0]       i_op;
  logic [2:0]       i_funct3;
  logic [XLEN-1:0]  i_pc, i_imm, i_rs1, i_rs2;
  logic             i_pred_taken;
  logic [XLEN-1:0]  i_pred_target;
  logic             o_valid, i_ready;
  logic             o_taken, o_mispredict, o_illegal, o_br_less, o_br_equal;
  logic [XLEN-1:0]  o_target, o_link, o_redirect_pc;
  logic [CNT_W-1:0] o_cnt_branch, o_cnt_mispred;
  modport master (
    output i_flush, i_valid, i_op, i_funct3, i_pc, i_imm, i_rs1, i_rs2,
           i_pred_taken, i_pred_target, i_ready,
    input  o_ready, o_valid, o_taken, o_mispredict, o_illegal, o_br_less, o_br_equal,
           o_target, o_link, o_redirect_pc, o_cnt_branch, o_cnt_mispred
  );
  modport slave (
    input  i_flush, i_valid, i_op, i_funct3, i_pc, i_imm, i_rs1, i_rs2,
           i_pred_taken, i_pred_target, i_ready,
    output o_ready, o_valid, o_taken, o_mispredict, o_illegal, o_br_less, o_br_equal,
           o_target, o_link, o_redirect_pc, o_cnt_branch, o_cnt_mispred
  );
endinterface

// File: rtl/bru_cmp.sv
// bru_cmp: signed/unsigned less and full-width equal from one XLEN+1-bit subtraction
module bru_cmp #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            uns,
  output logic            less,
  output logic            equal
);
  logic [XLEN:0] diff;
  assign diff  = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
  assign less  = uns ? !diff[XLEN] : (a[XLEN-1] == b[XLEN-1] ? diff[XLEN-1] : a[XLEN-1]);
  assign equal = a == b;
endmodule

// File: rtl/bru_pipe.sv
// bru_pipe: two-stage branch resolution unit with redirect; BRU_PERF_CNT_EN builds the perf counters
module bru_pipe
  import bru_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic       i_clk,
  input logic       i_reset,
  bru_pipe_if.slave bus
);
  bru_op_e         op_in;
  logic            less, equal, s2_adv, kill, accept;
  logic            s1_valid_q, s2_valid_q;
  bru_s1_t         s1_q;
  logic [XLEN-1:0] s1_target_q, s1_link_q, s1_ptgt_q;
  logic [XLEN-1:0] target_d, link_d;
  logic            taken_d, illegal_d, mispred_d;
  logic            taken_q, mispred_q, illegal_q, less_q, equal_q;
  logic [XLEN-1:0] target_q, link_q, redirect_q;
  assign op_in  = bru_op_e'(bus.i_op);
  assign s2_adv = !s2_valid_q || bus.i_ready;
  assign kill   = s2_valid_q && bus.i_ready && mispred_q;
  assign bus.o_ready = !bus.i_flush && !kill && (!s1_valid_q || s2_adv);
  assign accept = bus.i_valid && bus.o_ready;
  bru_cmp #(.XLEN(XLEN)) u_cmp (
    .a     (bus.i_rs1),
    .b     (bus.i_rs2),
    .uns   (bus.i_funct3 == F3_BLTU || bus.i_funct3 == F3_BGEU),
    .less  (less),
    .equal (equal)
  );
  // target/link for the incoming entry and the direction decision for the S1 entry
  always_comb begin
    link_d    = bus.i_pc + XLEN'(LINK_OFFSET);
    target_d  = op_in == OP_JALR ? (bus.i_rs1 + bus.i_imm) & ~XLEN'(1) :
                op_in == OP_NONE ? link_d : bus.i_pc + bus.i_imm;
    illegal_d = s1_q.op == OP_BR && br_illegal(s1_q.funct3);
    taken_d   = s1_q.op == OP_JAL || s1_q.op == OP_JALR ||
                (s1_q.op == OP_BR && !illegal_d && br_cond(s1_q.funct3, s1_q.less, s1_q.equal));
    mispred_d = taken_d != s1_q.pred_taken || (taken_d && s1_target_q != s1_ptgt_q);
  end
  // S1: compare flags, target, link and decode fields; wrong-path entry dropped on self-kill
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s1_target_q <= '0;
      s1_link_q   <= '0;
      s1_ptgt_q   <= '0;
    end else begin
      if (bus.i_flush || kill) s1_valid_q <= 1'b0;
      else if (!s1_valid_q || s2_adv) s1_valid_q <= bus.i_valid;
      if (accept) begin
        s1_q        <= '{op: op_in, funct3: bus.i_funct3, less: less, equal: equal,
                         pred_taken: bus.i_pred_taken};
        s1_target_q <= target_d;
        s1_link_q   <= link_d;
        s1_ptgt_q   <= bus.i_pred_target;
      end
    end
  end
  // S2: registered decision and result, held while downstream stalls
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s2_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      mispred_q  <= 1'b0;
      illegal_q  <= 1'b0;
      less_q     <= 1'b0;
      equal_q    <= 1'b0;
      target_q   <= '0;
      link_q     <= '0;
      redirect_q <= '0;
    end else begin
      s2_valid_q <= !bus.i_flush && (s2_adv ? s1_valid_q && !kill : s2_valid_q);
      if (s2_adv && s1_valid_q) begin
        taken_q    <= taken_d;
        mispred_q  <= mispred_d;
        illegal_q  <= illegal_d;
        less_q     <= s1_q.less;
        equal_q    <= s1_q.equal;
        target_q   <= s1_target_q;
        link_q     <= s1_link_q;
        redirect_q <= taken_d ? s1_target_q : s1_link_q;
      end
    end
  end
  assign bus.o_valid       = s2_valid_q;
  assign bus.o_taken       = taken_q;
  assign bus.o_mispredict  = mispred_q;
  assign bus.o_illegal     = illegal_q;
  assign bus.o_br_less     = less_q;
  assign bus.o_br_equal    = equal_q;
  assign bus.o_target      = target_q;
  assign bus.o_link        = link_q;
  assign bus.o_redirect_pc = redirect_q;
`ifdef BRU_PERF_CNT_EN
  bru_op_e          op_q;
  logic             handoff;
  logic [CNT_W-1:0] cnt_br_q, cnt_mp_q;
  assign handoff = s2_valid_q && bus.i_ready && !bus.i_flush;
  // saturating counters over entries actually handed downstream
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_q     <= OP_NONE;
      cnt_br_q <= '0;
      cnt_mp_q <= '0;
    end else begin
      if (s2_adv && s1_valid_q) op_q <= s1_q.op;
      if (handoff && op_q != OP_NONE && cnt_br_q != '1) cnt_br_q <= cnt_br_q + CNT_W'(1);
      if (handoff && mispred_q && cnt_mp_q != '1) cnt_mp_q <= cnt_mp_q + CNT_W'(1);
    end
  end
  assign bus.o_cnt_branch  = cnt_br_q;
  assign bus.o_cnt_mispred = cnt_mp_q;
`else
  assign bus.o_cnt_branch  = '0;
  assign bus.o_cnt_mispred = '0;
`endif
endmodule
